// File: rtl/debug_unit_pkg.sv
// Shared definitions for the UART debug unit: command/reply codes, FSM states
// and the reply selector driving the transmit serializer.
package debug_unit_pkg;

  localparam int BYTE_W    = 8;
  localparam int CYC_CNT_W = 32;

  localparam logic [BYTE_W-1:0] CMD_LOAD    = 8'h01;
  localparam logic [BYTE_W-1:0] CMD_RUN     = 8'h02;
  localparam logic [BYTE_W-1:0] CMD_STEP    = 8'h03;
  localparam logic [BYTE_W-1:0] CMD_READ_PC = 8'h04;

  localparam logic [BYTE_W-1:0] REPLY_ACK = 8'hAA;
  localparam logic [BYTE_W-1:0] REPLY_ERR = 8'hEE;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LD_CNT,
    S_LD_BYTE,
    S_LD_WR,
    S_RUN,
    S_STEP,
    S_TX_SEND,
    S_TX_WAIT
  } state_t;

  // RPL_PC_CNT is the RUN/STEP reply; it only carries the cycle count when
  // the counter is built in.
  typedef enum logic [1:0] {
    RPL_ACK,
    RPL_ERR,
    RPL_PC,
    RPL_PC_CNT
  } reply_t;

endpackage

// File: rtl/debug_unit_tx_seq.sv
// Reply serializer: loads a payload and a byte count, then emits one tx_start
// per byte (LSB first), advancing only on tx_done from the UART transmitter.
module debug_unit_tx_seq
  import debug_unit_pkg::*;
#(
  parameter int PAYLOAD_W = 64,
  parameter int CNT_W     = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 load,
  input  logic [PAYLOAD_W-1:0] payload,
  input  logic [CNT_W-1:0]     count,
  input  logic                 tx_done,
  output logic                 tx_start,
  output logic [BYTE_W-1:0]    tx_data,
  output logic                 last
);

  logic [PAYLOAD_W-BYTE_W-1:0] shreg;
  logic [CNT_W-1:0]            remaining;
  logic                        active;

  // Combinational so the owner can leave its wait state on the same edge.
  assign last = active && tx_done && (remaining == '0);

  // NOTE: every register here is sequential state, so it is assigned with <=;
  // a blocking = would let later statements see the new value within one edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shreg     <= '0;
      remaining <= '0;
      active    <= 1'b0;
      tx_start  <= 1'b0;
      tx_data   <= '0;
    end else begin
      tx_start <= 1'b0;
      if (load) begin
        tx_data   <= payload[BYTE_W-1:0];
        shreg     <= payload[PAYLOAD_W-1:BYTE_W];
        remaining <= count - CNT_W'(1);
        tx_start  <= 1'b1;
        active    <= 1'b1;
      end else if (active && tx_done) begin
        if (remaining == '0) begin
          active <= 1'b0;
        end else begin
          tx_data   <= shreg[BYTE_W-1:0];
          shreg     <= shreg >> BYTE_W;
          remaining <= remaining - CNT_W'(1);
          tx_start  <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/debug_unit.sv
// Host-side UART debug controller: program load, run/step gating, PC readback.
// Define DEBUG_UNIT_CYCLE_COUNT_EN to append a 32-bit executed-cycle count to RUN/STEP replies.
module debug_unit
  import debug_unit_pkg::*;
#(
  parameter int NBITS   = 8,
  parameter int IMEM_AW = 8,
  parameter int PC_W    = 32
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [NBITS-1:0]   i_rx_data,
  input  logic               i_rx_done,
  input  logic               i_tx_done,
  output logic               o_tx_start,
  output logic [NBITS-1:0]   o_tx_data,
  output logic               o_imem_wr_en,
  output logic [IMEM_AW-1:0] o_imem_addr,
  output logic [31:0]        o_imem_data,
  output logic               o_cpu_en,
  input  logic [PC_W-1:0]    i_pc,
  input  logic               i_halt
);

  localparam int PC_BYTES  = PC_W / 8;
  localparam int PAYLOAD_W = PC_W + CYC_CNT_W;
  localparam int CNT_W     = $clog2(PC_BYTES + CYC_CNT_W / 8 + 1);

  state_t             state;
  reply_t             reply;
  logic [1:0]         byte_idx;
  logic [NBITS-1:0]   word_cnt;

  logic                 seq_load;
  logic                 seq_last;
  logic [PAYLOAD_W-1:0] seq_payload;
  logic [CNT_W-1:0]     seq_count;

`ifdef DEBUG_UNIT_CYCLE_COUNT_EN
  logic [CYC_CNT_W-1:0] cyc_cnt;
  logic                 exec_cmd;

  assign exec_cmd = (state == S_IDLE) && i_rx_done &&
                    (i_rx_data == CMD_RUN || i_rx_data == CMD_STEP);

  always_ff @(posedge i_clk) begin
    if (!i_rst)
      cyc_cnt <= '0;
    else if (exec_cmd)
      cyc_cnt <= '0;
    else if (o_cpu_en)
      cyc_cnt <= cyc_cnt + 32'd1;
  end
`endif

  // The serializer samples this on the TX_SEND edge, which is the PC snapshot.
  assign seq_load = (state == S_TX_SEND);

  // NOTE: defaults come first so no path leaves an output unassigned (no latch).
  always_comb begin
    seq_payload = PAYLOAD_W'(REPLY_ACK);
    seq_count   = CNT_W'(1);
    case (reply)
      RPL_ERR: seq_payload = PAYLOAD_W'(REPLY_ERR);
      RPL_PC: begin
        seq_payload = PAYLOAD_W'(i_pc);
        seq_count   = CNT_W'(PC_BYTES);
      end
      RPL_PC_CNT: begin
`ifdef DEBUG_UNIT_CYCLE_COUNT_EN
        seq_payload = {cyc_cnt, i_pc};
        seq_count   = CNT_W'(PC_BYTES + CYC_CNT_W / 8);
`else
        seq_payload = PAYLOAD_W'(i_pc);
        seq_count   = CNT_W'(PC_BYTES);
`endif
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      state        <= S_IDLE;
      reply        <= RPL_ACK;
      byte_idx     <= '0;
      word_cnt     <= '0;
      o_imem_wr_en <= 1'b0;
      o_imem_addr  <= '0;
      o_imem_data  <= '0;
      o_cpu_en     <= 1'b0;
    end else begin
      o_imem_wr_en <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (i_rx_done) begin
            case (i_rx_data)
              CMD_LOAD: state <= S_LD_CNT;
              CMD_RUN: begin
                o_cpu_en <= ~i_halt;
                reply    <= RPL_PC_CNT;
                state    <= S_RUN;
              end
              CMD_STEP: begin
                o_cpu_en <= 1'b1;
                reply    <= RPL_PC_CNT;
                state    <= S_STEP;
              end
              CMD_READ_PC: begin
                reply <= RPL_PC;
                state <= S_TX_SEND;
              end
              default: begin
                reply <= RPL_ERR;
                state <= S_TX_SEND;
              end
            endcase
          end
        end
        S_LD_CNT: begin
          if (i_rx_done) begin
            word_cnt    <= i_rx_data;
            o_imem_addr <= '0;
            byte_idx    <= '0;
            if (i_rx_data == '0) begin
              reply <= RPL_ACK;
              state <= S_TX_SEND;
            end else begin
              state <= S_LD_BYTE;
            end
          end
        end
        S_LD_BYTE: begin
          if (i_rx_done) begin
            o_imem_data[8*byte_idx +: 8] <= i_rx_data;
            byte_idx <= byte_idx + 2'd1;
            if (byte_idx == 2'd3) begin
              o_imem_wr_en <= 1'b1;
              state        <= S_LD_WR;
            end
          end
        end
        S_LD_WR: begin
          o_imem_addr <= o_imem_addr + IMEM_AW'(1);
          word_cnt    <= word_cnt - NBITS'(1);
          if (word_cnt == NBITS'(1)) begin
            reply <= RPL_ACK;
            state <= S_TX_SEND;
          end else begin
            state <= S_LD_BYTE;
          end
        end
        S_RUN: begin
          if (i_halt) begin
            o_cpu_en <= 1'b0;
            state    <= S_TX_SEND;
          end else begin
            o_cpu_en <= 1'b1;
          end
        end
        S_STEP: begin
          o_cpu_en <= 1'b0;
          state    <= S_TX_SEND;
        end
        S_TX_SEND: state <= S_TX_WAIT;
        S_TX_WAIT: if (seq_last) state <= S_IDLE;
        default:   state <= S_IDLE;
      endcase
    end
  end

  debug_unit_tx_seq #(
    .PAYLOAD_W (PAYLOAD_W),
    .CNT_W     (CNT_W)
  ) u_tx_seq (
    .clk      (i_clk),
    .rst_n    (i_rst),
    .load     (seq_load),
    .payload  (seq_payload),
    .count    (seq_count),
    .tx_done  (i_tx_done),
    .tx_start (o_tx_start),
    .tx_data  (o_tx_data),
    .last     (seq_last)
  );

endmodule

// File: tb/tb_debug_unit.sv
// Self-checking bench for debug_unit: directed test-plan cases plus a random
// command mix scored against a transaction-level model of expected writes/replies.
module tb_debug_unit;

  localparam int AW = 4;
`ifdef DEBUG_UNIT_CYCLE_COUNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic          i_clk = 1'b0;
  logic          i_rst = 1'b0;
  logic [7:0]    i_rx_data = '0;
  logic          i_rx_done = 1'b0;
  logic          i_tx_done = 1'b0;
  logic          o_tx_start;
  logic [7:0]    o_tx_data;
  logic          o_imem_wr_en;
  logic [AW-1:0] o_imem_addr;
  logic [31:0]   o_imem_data;
  logic          o_cpu_en;
  logic [31:0]   i_pc = '0;
  logic          i_halt = 1'b0;

  debug_unit #(.NBITS(8), .IMEM_AW(AW), .PC_W(32)) dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_rx_data    (i_rx_data),
    .i_rx_done    (i_rx_done),
    .i_tx_done    (i_tx_done),
    .o_tx_start   (o_tx_start),
    .o_tx_data    (o_tx_data),
    .o_imem_wr_en (o_imem_wr_en),
    .o_imem_addr  (o_imem_addr),
    .o_imem_data  (o_imem_data),
    .o_cpu_en     (o_cpu_en),
    .i_pc         (i_pc),
    .i_halt       (i_halt)
  );

  always #5 i_clk = ~i_clk;

  typedef struct { logic [7:0] b; bit first; } tx_exp_t;
  typedef struct { logic [AW-1:0] addr; logic [31:0] data; int cyc; } wr_exp_t;

  tx_exp_t     exp_tx[$];
  wr_exp_t     exp_wr[$];
  int          first_start_q[$];
  logic [7:0]  tx_log[$];
  logic [31:0] wr_log[$];

  int         n_cmp = 0;
  int         n_err = 0;
  int         cyc = 0;
  int         en_cycles = 0;
  int         done_edge = 0;
  bit         in_flight = 1'b0;
  logic [7:0] cur_byte = '0;

  always @(posedge i_clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Per-cycle scoreboard on the falling edge.
  initial begin : compare
    tx_exp_t e;
    wr_exp_t w;
    forever begin
      @(negedge i_clk);
      if (in_flight) check("tx_data_hold", o_tx_data, cur_byte);
      if (o_tx_start) begin
        check("tx_start_expected", exp_tx.size() != 0, 1);
        if (exp_tx.size() != 0) begin
          e = exp_tx.pop_front();
          check("tx_byte", o_tx_data, e.b);
          if (e.first) first_start_q.push_back(cyc);
          else check("tx_spacing", cyc, done_edge);
        end
        tx_log.push_back(o_tx_data);
        cur_byte  = o_tx_data;
        in_flight = 1'b1;
      end
      if (i_tx_done) begin
        in_flight = 1'b0;
        done_edge = cyc + 1;
      end
      if (o_imem_wr_en) begin
        check("wr_expected", exp_wr.size() != 0, 1);
        if (exp_wr.size() != 0) begin
          w = exp_wr.pop_front();
          check("wr_addr", o_imem_addr, w.addr);
          check("wr_data", o_imem_data, w.data);
          check("wr_cycle", cyc, w.cyc);
        end
        wr_log.push_back(o_imem_data);
      end
      if (o_cpu_en) en_cycles++;
    end
  end

  // UART transmitter stand-in: acknowledges each start after a random delay.
  initial begin : uart_model
    forever begin
      @(negedge i_clk);
      if (o_tx_start) begin
        repeat ($urandom_range(2, 6)) @(posedge i_clk);
        #1 i_tx_done = 1'b1;
        @(posedge i_clk);
        #1 i_tx_done = 1'b0;
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, output int c);
    @(posedge i_clk); #1;
    i_rx_data = b;
    i_rx_done = 1'b1;
    @(posedge i_clk); #1;
    c = cyc;
    i_rx_done = 1'b0;
  endtask

  task automatic push_single(input logic [7:0] b);
    exp_tx.push_back('{b: b, first: 1'b1});
  endtask

  task automatic push_pc(input logic [31:0] pc, input bit with_cnt, input int cnt);
    logic [31:0] c32;
    c32 = cnt;
    for (int i = 0; i < 4; i++) exp_tx.push_back('{b: pc[8*i +: 8], first: (i == 0)});
    if (CNT_EN && with_cnt)
      for (int i = 0; i < 4; i++) exp_tx.push_back('{b: c32[8*i +: 8], first: 1'b0});
  endtask

  task automatic wait_idle(input bit scramble);
    int n;
    n = 0;
    while ((exp_tx.size() != 0 || in_flight) && n < 400) begin
      @(posedge i_clk); #1;
      n++;
      if (scramble && first_start_q.size() != 0) i_pc = $urandom;
    end
    check("reply_complete", exp_tx.size(), 0);
    repeat (3) @(posedge i_clk);
    #1;
  endtask

  task automatic check_first(input int want);
    check("reply_started", first_start_q.size(), 1);
    if (first_start_q.size() != 0) check("first_start_cycle", first_start_q.pop_front(), want);
  endtask

  task automatic do_load(input logic [31:0] words[$]);
    int c, n, en0;
    n   = words.size();
    en0 = en_cycles;
    send_byte(8'h01, c);
    send_byte(n[7:0], c);
    for (int i = 0; i < n; i++) begin
      for (int k = 0; k < 4; k++) begin
        repeat ($urandom_range(0, 2)) @(posedge i_clk);
        send_byte(words[i][8*k +: 8], c);
      end
      exp_wr.push_back('{addr: AW'(i), data: words[i], cyc: c});
    end
    push_single(8'hAA);
    wait_idle(1'b0);
    check_first(n == 0 ? c + 1 : c + 2);
    check("load_cpu_en", en_cycles - en0, 0);
    check("load_writes_done", exp_wr.size(), 0);
  endtask

  task automatic do_run(input int h, input logic [31:0] pc, input bit drop);
    int c, d, en0;
    en0    = en_cycles;
    i_pc   = pc;
    i_halt = (h == 0);
    push_pc(pc, 1'b1, h);
    send_byte(8'h02, c);
    if (drop && h >= 4) send_byte(8'h03, d);
    if (h >= 1) begin
      while (cyc < c + h - 1) begin @(posedge i_clk); #1; end
      i_halt = 1'b1;
    end
    wait_idle(1'b1);
    check_first(c + (h > 1 ? h : 1) + 1);
    check("run_cpu_en_cycles", en_cycles - en0, h);
    i_halt = 1'b0;
  endtask

  task automatic do_step(input logic [31:0] pc, input logic halt);
    int c, en0;
    en0    = en_cycles;
    i_pc   = pc;
    i_halt = halt;
    push_pc(pc, 1'b1, 1);
    send_byte(8'h03, c);
    wait_idle(1'b1);
    check_first(c + 2);
    check("step_cpu_en_cycles", en_cycles - en0, 1);
    i_halt = 1'b0;
  endtask

  task automatic do_read_pc(input logic [31:0] pc);
    int c, en0;
    en0  = en_cycles;
    i_pc = pc;
    push_pc(pc, 1'b0, 0);
    send_byte(8'h04, c);
    wait_idle(1'b1);
    check_first(c + 1);
    check("read_pc_cpu_en", en_cycles - en0, 0);
  endtask

  task automatic do_bad(input logic [7:0] b, input bit drop);
    int c, d, en0;
    en0 = en_cycles;
    push_single(8'hEE);
    send_byte(b, c);
    if (drop) send_byte(8'h02, d);
    wait_idle(1'b0);
    repeat (10) @(posedge i_clk);
    #1;
    check_first(c + 1);
    check("bad_cpu_en", en_cycles - en0, 0);
  endtask

  function automatic logic [31:0] log_word(input int base);
    return {tx_log[base+3], tx_log[base+2], tx_log[base+1], tx_log[base]};
  endfunction

  task automatic check_reset_outputs(input string tag);
    check({tag, "_tx_start"}, o_tx_start, 0);
    check({tag, "_tx_data"}, o_tx_data, 0);
    check({tag, "_wr_en"}, o_imem_wr_en, 0);
    check({tag, "_addr"}, o_imem_addr, 0);
    check({tag, "_data"}, o_imem_data, 0);
    check({tag, "_cpu_en"}, o_cpu_en, 0);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    logic [31:0] words[$];
    int base, wbase, c, op, n;
    logic [7:0] b;

    repeat (3) @(posedge i_clk);
    @(negedge i_clk);
    check_reset_outputs("por");
    #1 i_rst = 1'b1;
    repeat (2) @(posedge i_clk);
    #1;

    // Directed LOAD of two words.
    wbase = wr_log.size();
    base  = tx_log.size();
    words = '{32'h12345678, 32'hDEADBEEF};
    do_load(words);
    check("dir_load_w0", wr_log[wbase], 32'h12345678);
    check("dir_load_w1", wr_log[wbase+1], 32'hDEADBEEF);
    check("dir_load_ack", tx_log[base], 8'hAA);

    // Directed STEP at PC 4.
    base = tx_log.size();
    do_step(32'h00000004, 1'b0);
    check("dir_step_pc", log_word(base), 32'h00000004);

    // Directed RUN, halt after 10 enabled cycles, PC 0x40.
    base = tx_log.size();
    do_run(10, 32'h00000040, 1'b0);
    check("dir_run_pc", log_word(base), 32'h00000040);
    if (CNT_EN) check("dir_run_cnt", log_word(base + 4), 32'h0000000A);
    check("dir_run_len", tx_log.size() - base, CNT_EN ? 8 : 4);

    // Unknown command with a dropped byte during the reply.
    base = tx_log.size();
    do_bad(8'h7F, 1'b1);
    check("dir_bad_err", tx_log[base], 8'hEE);
    check("dir_bad_len", tx_log.size() - base, 1);

    // Empty LOAD, then READ_PC.
    wbase = wr_log.size();
    words = {};
    do_load(words);
    check("dir_empty_no_write", wr_log.size() - wbase, 0);
    base = tx_log.size();
    do_read_pc(32'hCAFE0123);
    check("dir_read_pc", log_word(base), 32'hCAFE0123);

    // Reset in the middle of a word, after two of its four bytes.
    wbase = wr_log.size();
    send_byte(8'h01, c);
    send_byte(8'h01, c);
    send_byte(8'h78, c);
    send_byte(8'h56, c);
    @(posedge i_clk); #1 i_rst = 1'b0;
    @(posedge i_clk); #1 i_rst = 1'b1;
    @(negedge i_clk);
    check_reset_outputs("midload_rst");
    repeat (3) @(posedge i_clk);
    #1;
    check("midload_no_write", wr_log.size() - wbase, 0);
    do_read_pc(32'h00001000);
    words = '{32'hA5A5_0F0F};
    do_load(words);

    // Run with halt already high, and a run with a byte dropped mid-run.
    do_run(0, 32'h00000100, 1'b0);
    do_run(6, 32'h00000200, 1'b1);

    // Address wrap past the 16-word window.
    words = {};
    for (int i = 0; i < 20; i++) words.push_back($urandom);
    do_load(words);

    // Random command mix.
    for (int it = 0; it < 30; it++) begin
      op = $urandom_range(0, 4);
      case (op)
        0: begin
          words = {};
          n = ($urandom_range(0, 4) == 0) ? $urandom_range(0, 18) : $urandom_range(1, 3);
          for (int i = 0; i < n; i++) words.push_back($urandom);
          do_load(words);
        end
        1: do_run($urandom_range(0, 12), $urandom, $urandom_range(0, 1) == 1);
        2: do_step($urandom, $urandom_range(0, 1) == 1);
        3: do_read_pc($urandom);
        default: begin
          b = 8'($urandom_range(0, 255));
          if (b >= 8'h01 && b <= 8'h04) b = 8'h7F;
          do_bad(b, $urandom_range(0, 1) == 1);
        end
      endcase
    end

    repeat (20) @(posedge i_clk);
    #1;
    check("final_tx_queue_empty", exp_tx.size(), 0);
    check("final_wr_queue_empty", exp_wr.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
